// File: rtl/event_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : event_dispatch_ctrl
// Description : Edge-qualified event latch with round-robin valid/ready
//               dispatch to a single handler. Optional saturating drop
//               counter built when EVENT_DISPATCH_DROPCNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module event_dispatch_ctrl #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   src_i,
  input  logic [N_SRC-1:0]   iff_i,
  input  logic [2*N_SRC-1:0] cfg_mode,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic               evt_rise,
  output logic [N_SRC-1:0]   pending_o,
  output logic               overflow_o,
  output logic [7:0]         drop_cnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [0:0]       r_state;
  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_kind;
  logic             r_valid;
  logic [ID_W-1:0]  r_id;
  logic             r_rise;
  logic [ID_W-1:0]  r_last_grant;
  logic             r_overflow;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_fall;
  logic [N_SRC-1:0] w_fire;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_busy;
  logic [N_SRC-1:0] w_drop;
  logic [N_SRC-1:0] w_accept;
  logic             w_hs;
  logic             w_gnt_found;
  logic [ID_W-1:0]  w_gnt_id;

  assign w_rise = src_i & ~r_src_q;
  assign w_fall = ~src_i & r_src_q;

  always_comb begin
    w_fire = '0;
    for (int i = 0; i < N_SRC; i++) begin
      case (cfg_mode[2*i +: 2])
        2'b01:   w_fire[i] = iff_i[i] & w_rise[i];
        2'b10:   w_fire[i] = iff_i[i] & w_fall[i];
        2'b11:   w_fire[i] = iff_i[i] & (w_rise[i] | w_fall[i]);
        default: w_fire[i] = 1'b0;
      endcase
    end
  end

  // A pending bit being cleared by this cycle's handshake can absorb a new
  // event on the same source without counting as a drop.
  assign w_hs     = (r_state == S_OFFER) & evt_ready;
  assign w_clr    = w_hs ? (N_SRC'(1) << r_id) : '0;
  assign w_busy   = r_pending & ~w_clr;
  assign w_drop   = w_fire & w_busy;
  assign w_accept = w_fire & ~w_busy;

  // Round-robin search starting just after the last granted source.
  always_comb begin
    int idx;
    idx         = 0;
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    for (int off = 1; off <= N_SRC; off++) begin
      idx = (int'(r_last_grant) + off) % N_SRC;
      if (!w_gnt_found && r_pending[idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_src_q      <= '0;
      r_pending    <= '0;
      r_kind       <= '0;
      r_valid      <= 1'b0;
      r_id         <= '0;
      r_rise       <= 1'b0;
      r_last_grant <= ID_W'(N_SRC - 1);
      r_overflow   <= 1'b0;
    end else begin
      r_src_q   <= src_i;
      r_pending <= w_busy | w_fire;
      r_kind    <= (r_kind & ~w_accept) | (w_rise & w_accept);
      if (|w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_id    <= w_gnt_id;
            r_rise  <= r_kind[w_gnt_id];
            r_valid <= 1'b1;
            r_state <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (evt_ready) begin
            r_valid      <= 1'b0;
            r_last_grant <= r_id;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef EVENT_DISPATCH_DROPCNT_EN
  logic [7:0] r_drop_cnt;
  logic [8:0] w_drop_sum;

  always_comb begin
    w_drop_sum = {1'b0, r_drop_cnt};
    for (int i = 0; i < N_SRC; i++) begin
      w_drop_sum = w_drop_sum + 9'(w_drop[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else begin
      r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'd0;
`endif

  assign evt_valid  = r_valid;
  assign evt_id     = r_id;
  assign evt_rise   = r_rise;
  assign pending_o  = r_pending;
  assign overflow_o = r_overflow;

endmodule
`default_nettype wire
